// File: rtl/rmii_phy_loopback_if.sv
// RMII pin bundle between a MAC (master) and the loopback PHY endpoint (slave),
// plus the endpoint's status outputs.
interface rmii_phy_loopback_if;
    logic        enable;
    logic        rmii_txen;
    logic [1:0]  rmii_txd;
    logic        rmii_crsdv;
    logic [1:0]  rmii_rxd;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    modport master (
        output enable, rmii_txen, rmii_txd,
        input  rmii_crsdv, rmii_rxd, busy, frame_cnt, drop_cnt
    );

    modport slave (
        input  enable, rmii_txen, rmii_txd,
        output rmii_crsdv, rmii_rxd, busy, frame_cnt, drop_cnt
    );
endinterface

// File: rtl/rmii_phy_loopback.sv
// PHY-side RMII loopback: captures each well-formed MAC frame after its SFD into a
// byte buffer, then replays it with regenerated preamble/SFD after an inter-frame gap.
module rmii_phy_loopback #(
    parameter int BUF_DEPTH  = 2048,
    parameter int IFG_CYCLES = 48,
    parameter int PRE_LEN    = 7
) (
    input logic               clk,
    input logic               rst,
    rmii_phy_loopback_if.slave bus
);

    localparam int AW         = $clog2(BUF_DEPTH);
    localparam int LW         = AW + 1;
    localparam int GW         = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int PRE_DIBITS = (PRE_LEN + 1) * 4;
    localparam int PW         = $clog2(PRE_DIBITS + 1);

    localparam logic [LW-1:0] MIN_LEN  = LW'(64);
    localparam logic [LW-1:0] FULL_LEN = LW'(BUF_DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(IFG_CYCLES - 1);
    localparam logic [PW-1:0] PRE_DONE = PW'(PRE_DIBITS);
    localparam logic [PW-1:0] SFD_LAST = PW'(PRE_DIBITS - 1);

    typedef enum logic [1:0] {C_IDLE, C_PRE, C_DATA, C_DISCARD} cap_state_t;
    typedef enum logic [1:0] {R_IDLE, R_GAP, R_PRE, R_DATA} rep_state_t;

    cap_state_t    c_state_reg;
    rep_state_t    r_state_reg;
    logic [7:0]    sr_reg;
    logic [LW-1:0] len_reg;
    logic [1:0]    phase_reg;
    logic [15:0]   drop_cnt_reg;
    logic [15:0]   frame_cnt_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic [PW-1:0] pre_cnt_reg;
    logic [1:0]    dphase_reg;
    logic [LW-1:0] bidx_reg;
    logic [LW-1:0] rlen_reg;
    logic          crsdv_reg;
    logic [1:0]    rxd_reg;
    logic          busy_reg;

    logic [7:0]    mem [BUF_DEPTH];
    logic [7:0]    rd_data_reg;

    logic [7:0]    sr_shift;
    logic          byte_done;
    logic          wr_en;
    logic          overflow;
    logic          frame_end;
    logic          frame_ok;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign sr_shift  = {bus.rmii_txd, sr_reg[7:2]};
    assign byte_done = (c_state_reg == C_DATA) && bus.rmii_txen && (phase_reg == 2'd3);
    assign wr_en     = byte_done && (len_reg != FULL_LEN);
    assign overflow  = byte_done && (len_reg == FULL_LEN);
    assign frame_end = (c_state_reg == C_DATA) && !bus.rmii_txen;
    assign frame_ok  = frame_end && (phase_reg == 2'd0) && (len_reg >= MIN_LEN);

    // Reads happen one cycle ahead of use: byte 0 on the last gap cycle, byte n+1
    // while the last dibit of byte n goes out, so the data stream has no bubbles.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        if (r_state_reg == R_GAP && gap_cnt_reg == GAP_LAST) begin
            rd_en = 1'b1;
        end else if (r_state_reg == R_DATA && dphase_reg == 2'd3) begin
            rd_en   = 1'b1;
            rd_addr = bidx_reg[AW-1:0] + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[len_reg[AW-1:0]] <= sr_shift;
        if (rd_en) rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_state_reg  <= C_IDLE;
            sr_reg       <= '0;
            len_reg      <= '0;
            phase_reg    <= '0;
            drop_cnt_reg <= '0;
        end else begin
            case (c_state_reg)
                C_IDLE: begin
                    if (bus.rmii_txen && bus.enable) begin
                        if (r_state_reg == R_IDLE) begin
                            c_state_reg <= C_PRE;
                            sr_reg      <= {bus.rmii_txd, 6'b0};
                        end else begin
                            c_state_reg  <= C_DISCARD;
                            drop_cnt_reg <= sat_inc(drop_cnt_reg);
                        end
                    end
                end
                C_PRE: begin
                    if (!bus.rmii_txen) begin
                        c_state_reg  <= C_IDLE;
                        drop_cnt_reg <= sat_inc(drop_cnt_reg);
                    end else begin
                        sr_reg <= sr_shift;
                        if (sr_shift == 8'hD5) begin
                            c_state_reg <= C_DATA;
                            len_reg     <= '0;
                            phase_reg   <= '0;
                        end
                    end
                end
                C_DATA: begin
                    if (!bus.rmii_txen) begin
                        c_state_reg <= C_IDLE;
                        if (!frame_ok) drop_cnt_reg <= sat_inc(drop_cnt_reg);
                    end else begin
                        sr_reg    <= sr_shift;
                        phase_reg <= phase_reg + 2'd1;
                        if (overflow) begin
                            c_state_reg  <= C_DISCARD;
                            drop_cnt_reg <= sat_inc(drop_cnt_reg);
                        end else if (wr_en) begin
                            len_reg <= len_reg + LW'(1);
                        end
                    end
                end
                C_DISCARD: begin
                    if (!bus.rmii_txen) c_state_reg <= C_IDLE;
                end
                default: c_state_reg <= C_IDLE;
            endcase
        end
    end

    // Outputs are registered with the dibit chosen on the transition edge, so
    // crsdv/rxd already carry the first preamble dibit in the first R_PRE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_reg   <= R_IDLE;
            gap_cnt_reg   <= '0;
            pre_cnt_reg   <= '0;
            dphase_reg    <= '0;
            bidx_reg      <= '0;
            rlen_reg      <= '0;
            crsdv_reg     <= 1'b0;
            rxd_reg       <= 2'b00;
            frame_cnt_reg <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    crsdv_reg <= 1'b0;
                    rxd_reg   <= 2'b00;
                    if (frame_ok) begin
                        r_state_reg <= R_GAP;
                        gap_cnt_reg <= '0;
                        rlen_reg    <= len_reg;
                    end
                end
                R_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        r_state_reg <= R_PRE;
                        crsdv_reg   <= 1'b1;
                        rxd_reg     <= 2'b01;
                        pre_cnt_reg <= PW'(1);
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    end
                end
                R_PRE: begin
                    if (pre_cnt_reg == PRE_DONE) begin
                        r_state_reg <= R_DATA;
                        rxd_reg     <= rd_data_reg[1:0];
                        dphase_reg  <= 2'd1;
                        bidx_reg    <= '0;
                    end else begin
                        rxd_reg     <= (pre_cnt_reg == SFD_LAST) ? 2'b11 : 2'b01;
                        pre_cnt_reg <= pre_cnt_reg + PW'(1);
                    end
                end
                R_DATA: begin
                    if (dphase_reg == 2'd0 && bidx_reg == rlen_reg) begin
                        r_state_reg   <= R_IDLE;
                        crsdv_reg     <= 1'b0;
                        rxd_reg       <= 2'b00;
                        frame_cnt_reg <= sat_inc(frame_cnt_reg);
                    end else begin
                        rxd_reg    <= rd_data_reg[{dphase_reg, 1'b0} +: 2];
                        dphase_reg <= dphase_reg + 2'd1;
                        if (dphase_reg == 2'd3) bidx_reg <= bidx_reg + LW'(1);
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_reg <= 1'b0;
        else     busy_reg <= (c_state_reg != C_IDLE) || (r_state_reg != R_IDLE);
    end

    assign bus.rmii_crsdv = crsdv_reg;
    assign bus.rmii_rxd   = rxd_reg;
    assign bus.busy       = busy_reg;
    assign bus.frame_cnt  = frame_cnt_reg;
    assign bus.drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_rmii_phy_loopback.sv
// Bench for rmii_phy_loopback: table of frame scenarios plus overlap and reset
// sequences; a negedge monitor checks replayed dibits against a scoreboard queue.
module tb_rmii_phy_loopback;
    localparam int DEPTH = 128;
    localparam int IFG   = 48;
    localparam int PRE   = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    rmii_phy_loopback_if bus ();

    rmii_phy_loopback #(
        .BUF_DEPTH  (DEPTH),
        .IFG_CYCLES (IFG),
        .PRE_LEN    (PRE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;
    logic       prev_crsdv = 1'b0;
    int         rise_cyc   = -1;
    int         high_len   = -1;
    bit         busy_seen  = 1'b0;

    typedef struct {
        bit do_reset;
        int nbytes;
        int extra;
        int seed;
        bit en;
        bit replay;
        int exp_frame;
        int exp_drop;
    } vec_t;

    vec_t vecs[10];

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (bus.rmii_crsdv) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_crsdv cyc=%0d: got crsdv=1 rxd=%0d, required crsdv=0", cyc, bus.rmii_rxd);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (bus.rmii_rxd !== mon_exp) begin
                        errors++;
                        $display("FAIL rxd_dibit cyc=%0d: got %0d required %0d", cyc, bus.rmii_rxd, mon_exp);
                    end
                end
            end else if (bus.rmii_rxd !== 2'b00) begin
                errors++;
                $display("FAIL idle_rxd cyc=%0d: got %0d required 0", cyc, bus.rmii_rxd);
            end
            if (bus.rmii_crsdv && !prev_crsdv) rise_cyc = cyc;
            if (!bus.rmii_crsdv && prev_crsdv) high_len = cyc - rise_cyc;
            if (bus.busy) busy_seen = 1'b1;
        end
        prev_crsdv = bus.rmii_crsdv;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b[1:0]);
        exp_q.push_back(b[3:2]);
        exp_q.push_back(b[5:4]);
        exp_q.push_back(b[7:6]);
    endtask

    task automatic push_frame(input int nbytes, input int seed);
        for (int i = 0; i < PRE; i++) push_byte(8'h55);
        push_byte(8'hD5);
        for (int i = 0; i < nbytes; i++) push_byte(8'(i + seed));
    endtask

    task automatic put_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) begin
            bus.rmii_txd = b[2*k +: 2];
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int nbytes, input int extra, input int seed, output int t_end);
        @(negedge clk);
        bus.rmii_txen = 1'b1;
        for (int i = 0; i < PRE; i++) put_byte(8'h55);
        put_byte(8'hD5);
        for (int i = 0; i < nbytes; i++) put_byte(8'(i + seed));
        for (int i = 0; i < extra; i++) begin
            bus.rmii_txd = 2'b10;
            @(negedge clk);
        end
        bus.rmii_txen = 1'b0;
        bus.rmii_txd  = 2'b00;
        t_end = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        repeat (4) @(negedge clk);
        while (!(bus.rmii_crsdv == 1'b0 && exp_q.size() == 0 && bus.busy == 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", (n >= budget) ? 1 : 0, 0);
    endtask

    task automatic wait_rise(input int budget);
        int n = 0;
        while (rise_cyc == -1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rise_timeout", (n >= budget) ? 1 : 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_end;
        bus.enable    = 1'b1;
        bus.rmii_txen = 1'b0;
        bus.rmii_txd  = 2'b00;

        vecs[0] = '{1'b1,  64, 0, 8'h00, 1'b1, 1'b1, 1, 0};
        vecs[1] = '{1'b0,  80, 0, 8'h5A, 1'b1, 1'b1, 2, 0};
        vecs[2] = '{1'b1,  40, 0, 8'h00, 1'b1, 1'b0, 0, 1};
        vecs[3] = '{1'b0,  64, 1, 8'h00, 1'b1, 1'b0, 0, 2};
        vecs[4] = '{1'b0,  63, 0, 8'h11, 1'b1, 1'b0, 0, 3};
        vecs[5] = '{1'b1, 200, 0, 8'h00, 1'b1, 1'b0, 0, 1};
        vecs[6] = '{1'b0, 100, 0, 8'h33, 1'b1, 1'b1, 1, 1};
        vecs[7] = '{1'b1, 128, 0, 8'h80, 1'b1, 1'b1, 1, 0};
        vecs[8] = '{1'b0, 129, 0, 8'h80, 1'b1, 1'b0, 1, 1};
        vecs[9] = '{1'b1,  64, 0, 8'h00, 1'b0, 1'b0, 0, 0};

        #2 rst = 1'b1;
        #1;
        check("reset_crsdv", int'(bus.rmii_crsdv), 0);
        check("reset_rxd", int'(bus.rmii_rxd), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_frame_cnt", int'(bus.frame_cnt), 0);
        check("reset_drop_cnt", int'(bus.drop_cnt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 10; r++) begin
            if (vecs[r].do_reset) do_reset();
            busy_seen  = 1'b0;
            rise_cyc   = -1;
            high_len   = -1;
            bus.enable = vecs[r].en;
            if (vecs[r].replay) push_frame(vecs[r].nbytes, vecs[r].seed);
            send_frame(vecs[r].nbytes, vecs[r].extra, vecs[r].seed, t_end);
            wait_idle(3000);
            if (!vecs[r].replay) repeat (IFG + 40) @(negedge clk);
            check($sformatf("row%0d_frame_cnt", r), int'(bus.frame_cnt), vecs[r].exp_frame);
            check($sformatf("row%0d_drop_cnt", r), int'(bus.drop_cnt), vecs[r].exp_drop);
            if (vecs[r].replay) begin
                check($sformatf("row%0d_latency", r), rise_cyc - t_end, IFG + 1);
                check($sformatf("row%0d_high_len", r), high_len, (PRE + 1) * 4 + 4 * vecs[r].nbytes);
            end else begin
                check($sformatf("row%0d_no_crsdv", r), rise_cyc, -1);
            end
            if (!vecs[r].en) check($sformatf("row%0d_busy_seen", r), int'(busy_seen), 0);
            $display("row %0d: bytes=%0d extra=%0d en=%0d frame_cnt=%0d drop_cnt=%0d rise_after=%0d high=%0d",
                     r, vecs[r].nbytes, vecs[r].extra, vecs[r].en, bus.frame_cnt, bus.drop_cnt,
                     (rise_cyc < 0) ? -1 : rise_cyc - t_end, high_len);
        end
        bus.enable = 1'b1;

        // Overlap: second frame starts while the first is mid-replay.
        do_reset();
        rise_cyc = -1;
        high_len = -1;
        push_frame(64, 8'h10);
        send_frame(64, 0, 8'h10, t_end);
        wait_rise(200);
        repeat (40) @(negedge clk);
        send_frame(64, 0, 8'hA0, t_end);
        check("overlap_drop_early", int'(bus.drop_cnt), 1);
        wait_idle(3000);
        check("overlap_frame_cnt", int'(bus.frame_cnt), 1);
        check("overlap_drop_cnt", int'(bus.drop_cnt), 1);
        check("overlap_high_len", high_len, (PRE + 1) * 4 + 4 * 64);
        $display("overlap: frame_cnt=%0d drop_cnt=%0d high=%0d", bus.frame_cnt, bus.drop_cnt, high_len);

        // Reset asserted in the middle of the data phase.
        rise_cyc = -1;
        push_frame(64, 8'h77);
        send_frame(64, 0, 8'h77, t_end);
        wait_rise(200);
        repeat (50) @(negedge clk);
        #5 rst = 1'b1;
        #1;
        check("midrst_crsdv", int'(bus.rmii_crsdv), 0);
        check("midrst_rxd", int'(bus.rmii_rxd), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_frame_cnt", int'(bus.frame_cnt), 0);
        check("midrst_drop_cnt", int'(bus.drop_cnt), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rise_cyc = -1;
        high_len = -1;
        push_frame(70, 8'h21);
        send_frame(70, 0, 8'h21, t_end);
        wait_idle(3000);
        check("postrst_frame_cnt", int'(bus.frame_cnt), 1);
        check("postrst_drop_cnt", int'(bus.drop_cnt), 0);
        check("postrst_latency", rise_cyc - t_end, IFG + 1);
        check("postrst_high_len", high_len, (PRE + 1) * 4 + 4 * 70);
        $display("reset_mid_replay: frame_cnt=%0d drop_cnt=%0d high=%0d", bus.frame_cnt, bus.drop_cnt, high_len);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
